pi_output_limiter: RTL and testbench

//  Downstream stage of the PI controller: takes the PI output word (signed Q1.15) and its valid

---
 rtl/pi_output_limiter.sv | 236 +++++++++++++++++++++++
 tb/tb_pi_output_limiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_output_limiter.sv
`default_nettype none
// ============================================================================
// Module   : pi_output_limiter
// Purpose  : Output stage of the PI controller. Clamps the PI output word to
//            a programmable window, applies a per-sample slew-rate limit and
//            drives the DAC word. Flags limiting back to the PI controller so
//            it can freeze its integrator. When enable drops, the DAC word is
//            ramped to zero before the block returns to idle.
// Ports    : clk, reset_n (sync, active low), enable
//            pi_output / pi_output_valid   signed input sample + strobe
//            limit_max / limit_min         signed clamp window
//            max_step                      unsigned slew limit, 0 = none
//            dac_data / dac_valid          signed output word + strobe
//            pi_limiting                   output differs from request
//            sat_high / sat_low            clamp active on this sample
//            cfg_error                     limit_min > limit_max
//            limit_count_clr / limit_count only with PI_LIMITER_COUNT_EN
// Options  : PI_LIMITER_COUNT_EN - adds a saturating counter of limited
//            output samples.
// Revision : 1.0 - initial release
// ============================================================================
module pi_output_limiter #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 15,
    parameter int STEP_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] pi_output,
    input  logic                         pi_output_valid,
    input  logic signed [DATA_WIDTH-1:0] limit_max,
    input  logic signed [DATA_WIDTH-1:0] limit_min,
    input  logic        [STEP_WIDTH-1:0] max_step,
`ifdef PI_LIMITER_COUNT_EN
    input  logic                         limit_count_clr,
    output logic                  [15:0] limit_count,
`endif
    output logic signed [DATA_WIDTH-1:0] dac_data,
    output logic                         dac_valid,
    output logic                         pi_limiting,
    output logic                         sat_high,
    output logic                         sat_low,
    output logic                         cfg_error
);

    // Wide enough to hold any difference of two data words and any step value
    // without overflow, plus a sign bit.
    localparam int c_CW = ((STEP_WIDTH > DATA_WIDTH) ? STEP_WIDTH : DATA_WIDTH) + 2;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_TRACK = 2'd1;
    localparam logic [1:0] c_PARK  = 2'd2;

    // The fractional position is purely interpretive, but it must fit.
    generate
        if (FRAC_BITS >= DATA_WIDTH) begin : g_frac_check
            $error("FRAC_BITS must be smaller than DATA_WIDTH");
        end
    endgenerate

    logic [1:0]                   r_state, w_state_nxt;
    logic signed [DATA_WIDTH-1:0] r_dac, w_dac_nxt;
    logic                         r_dac_valid, w_dac_valid_nxt;
    logic                         r_limiting, w_limiting_nxt;
    logic                         r_sat_high, w_sat_high_nxt;
    logic                         r_sat_low, w_sat_low_nxt;
    logic                         r_cfg_error;

    // Stage 1 (clamp) registers
    logic                         r_s1_valid;
    logic signed [DATA_WIDTH-1:0] r_s1_tgt;
    logic                         r_s1_sat_high;
    logic                         r_s1_sat_low;
    logic                         r_s1_cfg;

    // Clamp
    logic                         w_cfg_bad;
    logic signed [DATA_WIDTH-1:0] w_tgt;
    logic                         w_sat_high;
    logic                         w_sat_low;

    // Slew / park arithmetic
    logic        [DATA_WIDTH-1:0] w_step_d;
    logic signed [c_CW-1:0]       w_step_ext;
    logic signed [c_CW-1:0]       w_d;
    logic signed [c_CW-1:0]       w_abs_d;
    logic                         w_slew_lim;
    logic signed [DATA_WIDTH-1:0] w_slew_val;
    logic signed [c_CW-1:0]       w_dac_ext;
    logic signed [c_CW-1:0]       w_abs_dac;
    logic                         w_park_zero;
    logic signed [DATA_WIDTH-1:0] w_park_val;

    always_comb begin
        w_cfg_bad  = (limit_min > limit_max);
        w_tgt      = pi_output;
        w_sat_high = 1'b0;
        w_sat_low  = 1'b0;
        if (w_cfg_bad) begin
            // Unusable window: steer the output safely toward zero.
            w_tgt = '0;
        end else if (pi_output > limit_max) begin
            w_tgt      = limit_max;
            w_sat_high = 1'b1;
        end else if (pi_output < limit_min) begin
            w_tgt     = limit_min;
            w_sat_low = 1'b1;
        end
    end

    always_comb begin
        w_step_d   = DATA_WIDTH'(max_step);
        w_step_ext = c_CW'(max_step);

        w_d        = c_CW'(r_s1_tgt) - c_CW'(r_dac);
        w_abs_d    = w_d[c_CW-1] ? -w_d : w_d;
        w_slew_lim = (max_step != '0) && (w_abs_d > w_step_ext);
        // When limited, |d| > step, so the stepped value lies strictly between
        // r_dac and the target and wrap-around arithmetic is exact.
        w_slew_val = r_s1_tgt;
        if (w_slew_lim)
            w_slew_val = w_d[c_CW-1] ? (r_dac - w_step_d) : (r_dac + w_step_d);

        w_dac_ext   = c_CW'(r_dac);
        w_abs_dac   = w_dac_ext[c_CW-1] ? -w_dac_ext : w_dac_ext;
        w_park_zero = (max_step == '0) || (w_abs_dac <= w_step_ext);
        w_park_val  = '0;
        if (!w_park_zero)
            w_park_val = r_dac[DATA_WIDTH-1] ? (r_dac + w_step_d) : (r_dac - w_step_d);
    end

    // Next-state and output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_dac_nxt       = r_dac;
        w_dac_valid_nxt = 1'b0;
        w_limiting_nxt  = r_limiting;
        w_sat_high_nxt  = r_sat_high;
        w_sat_low_nxt   = r_sat_low;
        case (r_state)
            c_IDLE: begin
                w_dac_nxt      = '0;
                w_limiting_nxt = 1'b0;
                w_sat_high_nxt = 1'b0;
                w_sat_low_nxt  = 1'b0;
                if (enable && pi_output_valid)
                    w_state_nxt = c_TRACK;
            end
            c_TRACK: begin
                if (!enable) begin
                    // Whatever sits in stage 1 is dropped here.
                    w_state_nxt = c_PARK;
                end else if (r_s1_valid) begin
                    w_dac_nxt       = w_slew_val;
                    w_dac_valid_nxt = 1'b1;
                    w_sat_high_nxt  = r_s1_sat_high;
                    w_sat_low_nxt   = r_s1_sat_low;
                    w_limiting_nxt  = r_s1_sat_high | r_s1_sat_low | w_slew_lim | r_s1_cfg;
                end
            end
            c_PARK: begin
                if (enable && pi_output_valid) begin
                    // Resume tracking from the current output word.
                    w_state_nxt = c_TRACK;
                end else begin
                    w_dac_nxt       = w_park_val;
                    w_dac_valid_nxt = 1'b1;
                    w_sat_high_nxt  = 1'b0;
                    w_sat_low_nxt   = 1'b0;
                    w_limiting_nxt  = 1'b1;
                    if (w_park_zero) begin
                        w_state_nxt    = c_IDLE;
                        w_limiting_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_dac_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= c_IDLE;
            r_dac         <= '0;
            r_dac_valid   <= 1'b0;
            r_limiting    <= 1'b0;
            r_sat_high    <= 1'b0;
            r_sat_low     <= 1'b0;
            r_cfg_error   <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_tgt      <= '0;
            r_s1_sat_high <= 1'b0;
            r_s1_sat_low  <= 1'b0;
            r_s1_cfg      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_dac         <= w_dac_nxt;
            r_dac_valid   <= w_dac_valid_nxt;
            r_limiting    <= w_limiting_nxt;
            r_sat_high    <= w_sat_high_nxt;
            r_sat_low     <= w_sat_low_nxt;
            r_cfg_error   <= w_cfg_bad;
            r_s1_valid    <= enable & pi_output_valid;
            r_s1_tgt      <= w_tgt;
            r_s1_sat_high <= w_sat_high;
            r_s1_sat_low  <= w_sat_low;
            r_s1_cfg      <= w_cfg_bad;
        end
    end

    assign dac_data    = r_dac;
    assign dac_valid   = r_dac_valid;
    assign pi_limiting = r_limiting;
    assign sat_high    = r_sat_high;
    assign sat_low     = r_sat_low;
    assign cfg_error   = r_cfg_error;

`ifdef PI_LIMITER_COUNT_EN
    logic [15:0] r_limit_count;

    always_ff @(posedge clk) begin
        if (!reset_n || limit_count_clr)
            r_limit_count <= '0;
        else if (r_dac_valid && r_limiting && (r_limit_count != 16'hFFFF))
            r_limit_count <= r_limit_count + 16'd1;
    end

    assign limit_count = r_limit_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pi_output_limiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pi_output_limiter
// Purpose  : Directed self-checking bench for pi_output_limiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pi_output_limiter;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] pi_output;
    logic        pi_output_valid;
    logic [15:0] limit_max;
    logic [15:0] limit_min;
    logic [15:0] max_step;
    logic [15:0] dac_data;
    logic        dac_valid;
    logic        pi_limiting;
    logic        sat_high;
    logic        sat_low;
    logic        cfg_error;
`ifdef PI_LIMITER_COUNT_EN
    logic        limit_count_clr;
    logic [15:0] limit_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pi_output_limiter #(
        .DATA_WIDTH (16),
        .FRAC_BITS  (15),
        .STEP_WIDTH (16)
    ) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .pi_output       (pi_output),
        .pi_output_valid (pi_output_valid),
        .limit_max       (limit_max),
        .limit_min       (limit_min),
        .max_step        (max_step),
`ifdef PI_LIMITER_COUNT_EN
        .limit_count_clr (limit_count_clr),
        .limit_count     (limit_count),
`endif
        .dac_data        (dac_data),
        .dac_valid       (dac_valid),
        .pi_limiting     (pi_limiting),
        .sat_high        (sat_high),
        .sat_low         (sat_low),
        .cfg_error       (cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are stable 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] slew_exp [4];
    logic        slew_lim [4];

    initial begin
        reset_n         = 1'b0;
        enable          = 1'b0;
        pi_output       = 16'h0000;
        pi_output_valid = 1'b0;
        limit_max       = 16'h6000;
        limit_min       = 16'hA000;
        max_step        = 16'h0000;
`ifdef PI_LIMITER_COUNT_EN
        limit_count_clr = 1'b0;
`endif
        step();
        step();
        chk("rst_dac_data", dac_data, 16'h0000);
        chk("rst_dac_valid", dac_valid, 1'b0);
        chk("rst_limiting", pi_limiting, 1'b0);
        chk("rst_sat_high", sat_high, 1'b0);
        chk("rst_sat_low", sat_low, 1'b0);
        chk("rst_cfg_error", cfg_error, 1'b0);
        reset_n = 1'b1;
        step();

        // In-window sample passes through with 2-cycle latency
        enable          = 1'b1;
        pi_output       = 16'h4000;
        pi_output_valid = 1'b1;
        step();
        pi_output_valid = 1'b0;
        chk("t1_no_early_valid", dac_valid, 1'b0);
        step();
        chk("t1_dac_data", dac_data, 16'h4000);
        chk("t1_dac_valid", dac_valid, 1'b1);
        chk("t1_limiting", pi_limiting, 1'b0);
        step();
        chk("t1_valid_drop", dac_valid, 1'b0);
        chk("t1_hold", dac_data, 16'h4000);

        // Clamp at both limits
        pi_output       = 16'h7FFF;
        pi_output_valid = 1'b1;
        step();
        pi_output_valid = 1'b0;
        step();
        chk("t2_hi_dac", dac_data, 16'h6000);
        chk("t2_hi_sat", sat_high, 1'b1);
        chk("t2_hi_lim", pi_limiting, 1'b1);
        pi_output       = 16'h8000;
        pi_output_valid = 1'b1;
        step();
        pi_output_valid = 1'b0;
        step();
        chk("t2_lo_dac", dac_data, 16'hA000);
        chk("t2_lo_sat", sat_low, 1'b1);
        chk("t2_lo_sat_hi", sat_high, 1'b0);
        chk("t2_lo_lim", pi_limiting, 1'b1);

        // Return to zero, then slew toward 0x0350 in 0x0100 steps
        pi_output       = 16'h0000;
        pi_output_valid = 1'b1;
        step();
        pi_output_valid = 1'b0;
        step();
        chk("t3_pre_dac", dac_data, 16'h0000);
        chk("t3_pre_lim", pi_limiting, 1'b0);
        slew_exp = '{16'h0100, 16'h0200, 16'h0300, 16'h0350};
        slew_lim = '{1'b1, 1'b1, 1'b1, 1'b0};
        max_step        = 16'h0100;
        pi_output       = 16'h0350;
        pi_output_valid = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_slew_dac", dac_data, slew_exp[i]);
            chk("t3_slew_lim", pi_limiting, slew_lim[i]);
            if (i == 2)
                pi_output_valid = 1'b0;
        end
        step();
        chk("t3_valid_drop", dac_valid, 1'b0);

        // Ramp to zero on disable from 0x0250
        pi_output       = 16'h0250;
        pi_output_valid = 1'b1;
        step();
        pi_output_valid = 1'b0;
        step();
        chk("t4_start", dac_data, 16'h0250);
        enable = 1'b0;
        step();
        step();
        chk("t4_park1", dac_data, 16'h0150);
        chk("t4_park1_valid", dac_valid, 1'b1);
        chk("t4_park1_lim", pi_limiting, 1'b1);
        step();
        chk("t4_park2", dac_data, 16'h0050);
        step();
        chk("t4_park3", dac_data, 16'h0000);
        chk("t4_park3_valid", dac_valid, 1'b1);
        step();
        chk("t4_idle_valid", dac_valid, 1'b0);
        chk("t4_idle_dac", dac_data, 16'h0000);
        chk("t4_idle_lim", pi_limiting, 1'b0);

        // Inverted window: target forced to zero, output slews there
        max_step        = 16'h0000;
        enable          = 1'b1;
        pi_output       = 16'h0180;
        pi_output_valid = 1'b1;
        step();
        pi_output_valid = 1'b0;
        step();
        chk("t5_pre_dac", dac_data, 16'h0180);
        max_step        = 16'h0100;
        limit_min       = 16'h1000;
        limit_max       = 16'h0F00;
        pi_output       = 16'h4000;
        pi_output_valid = 1'b1;
        step();
        chk("t5_cfg_err", cfg_error, 1'b1);
        step();
        chk("t5_dac1", dac_data, 16'h0080);
        chk("t5_lim1", pi_limiting, 1'b1);
        chk("t5_sat_hi", sat_high, 1'b0);
        step();
        chk("t5_dac2", dac_data, 16'h0000);
        chk("t5_lim2", pi_limiting, 1'b1);
        limit_min       = 16'hA000;
        limit_max       = 16'h6000;
        pi_output_valid = 1'b0;
        step();
        chk("t5_cfg_clear", cfg_error, 1'b0);

        // Reset in the middle of a slew
        pi_output       = 16'h0500;
        pi_output_valid = 1'b1;
        step();
        step();
        step();
        chk("t6_mid_slew", dac_data, 16'h0200);
        reset_n         = 1'b0;
        enable          = 1'b0;
        pi_output_valid = 1'b0;
        step();
        chk("t6_rst_dac", dac_data, 16'h0000);
        chk("t6_rst_valid", dac_valid, 1'b0);
        chk("t6_rst_lim", pi_limiting, 1'b0);
        reset_n = 1'b1;
        step();
        step();
        chk("t6_idle_valid", dac_valid, 1'b0);

`ifdef PI_LIMITER_COUNT_EN
        max_step        = 16'h0000;
        enable          = 1'b1;
        pi_output       = 16'h7FFF;
        pi_output_valid = 1'b1;
        step();
        step();
        step();
        pi_output_valid = 1'b0;
        step();
        step();
        step();
        step();
        chk("t6_count", limit_count, 16'd3);
        limit_count_clr = 1'b1;
        step();
        limit_count_clr = 1'b0;
        chk("t6_count_clr", limit_count, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
